uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//   UART receiver for the bridge's serial ingress path. Deserialises 8N1 frames
//   from the external line. Consumes the same frame format the bridge transmitter
//   emits: start 0, LSB-first data, stop 1.
//   Delivers bytes through a one-entry valid/ready holding register to the
//   CAN framing logic. Uses oversampling with a 3-sample majority vote, and
//   flags framing and overrun errors.
// PARAMETERS
//   OVERSAMPLE   16  baud_tick pulses per bit; even, >= 8
//   DATA_BITS    8   data bits per frame, LSB first
//   SYNC_STAGES  2   flops in the serial_in synchroniser; >= 2
// PORTS
//   clock        in   1          system clock; all logic on posedge
//   reset        in   1          asynchronous, active-high
//   baud_tick    in   1          1-cycle enable at OVERSAMPLE x baud rate
//   serial_in    in   1          async line, idle high
//   rx_data      out  DATA_BITS  holding register contents
//   rx_valid     out  1          rx_data holds an unconsumed byte
//   rx_ready     in   1          consumer accepts when rx_valid && rx_ready
//   framing_err  out  1          1-cycle pulse: stop bit sampled 0
//   overrun_err  out  1          1-cycle pulse: completed byte dropped, holding reg full
//   rx_busy      out  1          FSM not in IDLE
// BEHAVIOUR
//   Reset
//   - Synchroniser flops = 1. FSM = IDLE. Counters = 0.
//   - rx_data = 0. rx_valid, framing_err, overrun_err, rx_busy = 0.
//   Sampling
//   - Tick counter s counts 0..OVERSAMPLE-1 on baud_tick only; it holds between ticks.
//   - Line is sampled at s = M-1, M, M+1, where M = OVERSAMPLE/2 (7, 8, 9 for 16).
//   - Bit value = majority of the 3 samples. Decision taken at s = M+1.
//   FSM
//   - IDLE: on baud_tick with synced line = 0 -> START, s = 0.
//   - START: at decision, majority 1 -> IDLE (glitch rejected, no flags).
//     Majority 0 -> continue. At s = OVERSAMPLE-1 -> DATA, bit index = 0.
//   - DATA: each decision shifts the bit in LSB first.
//     At s = OVERSAMPLE-1 the index increments. After DATA_BITS bits -> STOP.
//   - STOP, majority 1: commit the byte at the decision tick, then -> IDLE.
//     Early return lets the receiver resync on back-to-back frames.
//   - STOP, majority 0: framing_err pulses at the decision; byte discarded; -> BRK.
//   - BRK: stays until synced line = 1 on a baud_tick, then -> IDLE.
//     A held-low break therefore produces exactly one framing_err.
//   - Illegal state -> IDLE.
//   Output handshake
//   - Commit with rx_valid = 0: rx_data loads, rx_valid = 1 the next cycle.
//   - rx_valid && rx_ready clears rx_valid the next cycle unless a commit coincides.
//   - Commit while rx_valid = 1 and rx_ready = 0: new byte dropped, rx_data unchanged,
//     overrun_err pulses 1 cycle.
//   - Commit coinciding with rx_valid && rx_ready: new byte loads, rx_valid stays 1,
//     no overrun.
//   - rx_data is stable while rx_valid = 1 and not accepted.
//   Latency
//   - Commit at mid-stop decision. rx_valid rises 1 clock after the stop decision tick.
//   Reset mid-frame
//   - Immediate return to reset values; the partial byte is lost, no flags.
//     The next falling edge after reset release starts a frame.
// TESTING
//   - Frame 0xA5, 16 ticks/bit -> rx_data = 0xA5, rx_valid = 1 one clk after the
//     stop-bit tick-9 decision; no flags.
//   - Start pulse low for 4 ticks only -> return to IDLE; rx_valid = 0; no flags;
//     the following 0x3C frame is received correctly.
//   - 0x55 with stop bit forced 0 for 40 ticks -> one framing_err pulse, rx_valid = 0;
//     IDLE after the line returns high.
//   - 0x11 then 0x22 back-to-back, rx_ready = 0 -> rx_data = 0x11, overrun_err pulse
//     at the 0x22 commit. Repeat with rx_ready = 1 on the commit cycle -> rx_data = 0x22,
//     no overrun.
//   - Single-tick glitch on data bit 3 of 0xF0, at sample 8 only -> majority vote
//     gives rx_data = 0xF0.
//   - Assert reset at data bit 4 of 0x81 -> all outputs 0 and rx_busy = 0 immediately;
//     the next 0x7E frame is received intact.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with oversampled 3-sample majority vote per bit,
// one-entry valid/ready holding register, and framing/overrun error pulses.
module uart_rx_oversample #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SW-1:0]          s_q, s_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   oerr_q, oerr_d;

  logic line, vote, decide, at_end, commit, accept;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], serial_in};
    s_d     = s_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    commit  = 1'b0;

    line   = sync_q[SYNC_STAGES-1];
    // samp_q[1] holds the s=M-1 sample, samp_q[0] the s=M sample; line is s=M+1
    vote   = (samp_q[1] & samp_q[0]) | (samp_q[1] & line) | (samp_q[0] & line);
    decide = (s_q == SW'(M + 1));
    at_end = (s_q == SW'(OVERSAMPLE - 1));
    accept = valid_q & rx_ready;

    if (baud_tick && state_q != IDLE && state_q != BRK) begin
      s_d = at_end ? '0 : s_q + 1'b1;
      if (s_q == SW'(M - 1) || s_q == SW'(M)) samp_d = {samp_q[0], line};
    end

    case (state_q)
      IDLE: begin
        if (baud_tick && !line) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (decide && vote) begin
            state_d = IDLE;
            s_d     = '0;
          end else if (at_end) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (at_end) begin
            if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
            else idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick && decide) begin
          s_d = '0;
          if (vote) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (baud_tick && line) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase

    if (commit) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '1;
      s_q     <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign overrun_err = oerr_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: line levels are built per baud tick,
// a frame-level decoder predicts bytes/flags, and a monitor checks DUT outputs.
module tb_uart_rx_oversample;

  logic       clock = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  int         exp_flags[$];  // 1 = framing, 2 = overrun
  bit         lv[$];         // line level seen at each baud tick
  bit         rdy_default;

  uart_rx_oversample #(.OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .serial_in(serial_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is a low start bit, 8 LSB-first bits and a stop bit,
  // 16 ticks each; every bit is judged by majority of ticks 8..10 into it
  // (counted from the first tick the line is seen low).
  function automatic bit maj(input int k);
    int ones = 0;
    for (int j = k; j < k + 3; j++) ones += (j < lv.size()) ? int'(lv[j]) : 1;
    return ones >= 2;
  endfunction

  function automatic void model();
    int i = 0;
    while (i < lv.size()) begin
      if (lv[i] == 1'b0) begin
        int t0 = i;
        if (maj(t0 + 8)) begin
          i = t0 + 11;
        end else begin
          logic [7:0] d;
          for (int b = 0; b < 8; b++) d[b] = maj(t0 + 16 * (b + 1) + 8);
          if (maj(t0 + 144 + 8)) begin
            exp_bytes.push_back(d);
            i = t0 + 155;
          end else begin
            int j = t0 + 155;
            exp_flags.push_back(1);
            while (j < lv.size() && lv[j] == 1'b0) j++;
            i = j + 1;
          end
        end
      end else begin
        i++;
      end
    end
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) lv.push_back(1'b1);
  endtask

  task automatic frame(input logic [7:0] d, input int stop_low);
    for (int k = 0; k < 16; k++) lv.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 16; k++) lv.push_back(d[b]);
    if (stop_low > 0) for (int k = 0; k < stop_low; k++) lv.push_back(1'b0);
    else idle(16);
  endtask

  // One baud period: drive level, let it synchronise, then a 1-cycle tick.
  task automatic tick(input bit level, input bit rp);
    serial_in = level;
    repeat (3) @(posedge clock);
    #1;
    baud_tick = 1'b1;
    if (rp) rx_ready = 1'b1;
    @(posedge clock);
    #1;
    baud_tick = 1'b0;
    if (rp) rx_ready = rdy_default;
  endtask

  task automatic run(input int rp_idx, input int chk_idx, input int stop_at);
    for (int k = 0; k < lv.size(); k++) begin
      if (k == stop_at) break;
      tick(lv[k], k == rp_idx);
      if (k == chk_idx - 1) begin
        chk("valid_before_stop_decision", rx_valid, 0);
        chk("busy_in_frame", rx_busy, 1);
      end
      if (k == chk_idx) chk("valid_after_stop_decision", rx_valid, 1);
    end
    lv.delete();
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("drained_valid", rx_valid, 0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", {24'd0, rx_data}, 32'hdead);
        else chk("rx_byte", {24'd0, rx_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (framing_err) begin
        if (exp_flags.size() == 0) chk("unexpected_framing", 1, 0);
        else chk("flag_framing", 1, exp_flags.pop_front());
      end
      if (overrun_err) begin
        if (exp_flags.size() == 0) chk("unexpected_overrun", 2, 0);
        else chk("flag_overrun", 2, exp_flags.pop_front());
      end
    end
  end

  initial begin
    reset       = 1'b1;
    baud_tick   = 1'b0;
    serial_in   = 1'b1;
    rx_ready    = 1'b1;
    rdy_default = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_data", rx_data, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_ferr", framing_err, 0);
    chk("reset_oerr", overrun_err, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 0xA5 with latency check at the stop-bit decision tick
    idle(2); frame(8'hA5, 0); idle(4); model();
    run(-1, 2 + 154, -1);

    // short start pulse rejected, then 0x3C
    idle(2);
    for (int k = 0; k < 4; k++) lv.push_back(1'b0);
    idle(20); frame(8'h3C, 0); idle(4); model();
    run(-1, -1, -1);

    // stop bit held low for 40 ticks
    idle(2); frame(8'h55, 40); idle(20); model();
    run(-1, -1, -1);
    chk("brk_exit_busy", rx_busy, 0);
    chk("framing_no_valid", rx_valid, 0);

    // back-to-back with holding register full: overrun, first byte kept
    rdy_default = 1'b0;
    rx_ready    = 1'b0;
    idle(2); frame(8'h11, 0); frame(8'h22, 0); idle(4);
    exp_bytes.push_back(8'h11);
    exp_flags.push_back(2);
    run(-1, -1, -1);
    drain();

    // same, but consumer accepts on the 0x22 commit cycle
    rx_ready = 1'b0;
    idle(2); frame(8'h11, 0); frame(8'h22, 0); idle(4);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    run(2 + 160 + 154, -1, -1);
    drain();
    rdy_default = 1'b1;

    // single-tick glitch on the middle sample of data bit 3
    idle(2); frame(8'hF0, 0); idle(4);
    lv[2 + 16 * 4 + 9] = 1'b1;
    model();
    run(-1, -1, -1);

    // reset during data bit 4 of 0x81
    idle(2); frame(8'h81, 0);
    run(-1, -1, 2 + 16 * 5 + 5);
    reset = 1'b1;
    #1;
    chk("midreset_data", rx_data, 0);
    chk("midreset_valid", rx_valid, 0);
    chk("midreset_busy", rx_busy, 0);
    chk("midreset_ferr", framing_err, 0);
    serial_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3); frame(8'h7E, 0); idle(4); model();
    run(-1, -1, -1);

    // randomized frames with occasional single-tick glitches
    for (int f = 0; f < 20; f++) begin
      int base;
      idle($urandom_range(6, 1));
      base = lv.size();
      frame(8'($urandom_range(255, 0)), 0);
      for (int k = base; k < lv.size(); k++)
        if ($urandom_range(99, 0) == 0) lv[k] = ~lv[k];
    end
    idle(200); model();
    run(-1, -1, -1);

    rx_ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("bytes_outstanding", exp_bytes.size(), 0);
    chk("flags_outstanding", exp_flags.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
